if_fetch_ctrl: RTL and testbench

Instruction-fetch controller for the LEGv8 IF stage. It owns the program counter and drives the read address of the combinational instruction memory. It registers each fetched word with its PC into a one-entry IF/ID output register behind a valid/ready handshake. It also handles branch redirects and flushes, and traps misaligned or out-of-range fetch addresses.

---
 rtl/if_fetch_ctrl_pkg.sv | 21 ++
 rtl/if_fetch_ctrl_out_reg.sv | 35 +++
 rtl/if_fetch_ctrl.sv | 108 ++++++++++
 tb/tb_if_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths, FSM encodings and the fetch-address legality check for the LEGv8 IF stage.
package if_fetch_ctrl_pkg;

    localparam int WORD      = 64;
    localparam int INST_SIZE = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    typedef struct packed {
        logic [WORD-1:0]      pc;
        logic [INST_SIZE-1:0] inst;
    } fetch_t;

    // A fetch is legal only when word aligned and inside the instruction memory.
    function automatic logic pc_is_legal(input logic [WORD-1:0] pc, input int unsigned words);
        return (pc[1:0] == 2'b00) && ({2'b00, pc[WORD-1:2]} < WORD'(words));
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_out_reg.sv
// One-entry IF/ID output register: holds a valid word until decode accepts it, flush wins.
module if_out_reg
    import if_fetch_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_flush,
    input  logic   i_load,
    input  fetch_t i_data,
    input  logic   i_ready,
    output logic   o_valid,
    output fetch_t o_data
);

    logic   r_valid;
    fetch_t r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/if_fetch_ctrl.sv
// LEGv8 instruction-fetch controller: owns the PC, fills the IF/ID register, handles
// redirects, traps illegal fetch addresses and counts instructions accepted by decode.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WORD-1:0]      imem_pc,
    input  logic [INST_SIZE-1:0] imem_inst,
    input  logic                 redirect_valid,
    input  logic [WORD-1:0]      redirect_pc,
    output logic                 if_valid,
    output logic [INST_SIZE-1:0] if_inst,
    output logic [WORD-1:0]      if_pc,
    input  logic                 id_ready,
    output logic                 fault,
    output logic [WORD-1:0]      fault_pc,
    output logic [31:0]          retired_cnt
);

    logic [1:0]      r_state;
    logic [WORD-1:0] r_pc;
    logic [WORD-1:0] r_fault_pc;
    logic [31:0]     r_retired;

    logic   w_in_run;
    logic   w_can_load;
    logic   w_legal;
    logic   w_flush;
    logic   w_fault_hit;
    logic   w_load;
    logic   w_transfer;
    fetch_t w_fetch;
    fetch_t w_out;

    assign w_in_run    = (r_state == ST_RUN);
    assign w_can_load  = !if_valid || id_ready;
    assign w_legal     = pc_is_legal(r_pc, MEM_WORDS);
    assign w_flush     = w_in_run && redirect_valid;
    assign w_fault_hit = w_in_run && !redirect_valid && w_can_load && !w_legal;
    assign w_load      = w_in_run && !redirect_valid && w_can_load && w_legal;
    // A word flushed by a same-cycle redirect never counts as retired.
    assign w_transfer  = if_valid && id_ready && !w_flush;

    assign w_fetch.pc   = r_pc;
    assign w_fetch.inst = imem_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_fault_pc <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_pc    <= RESET_PC;
                    end
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end else if (w_fault_hit) begin
                        r_state    <= ST_FAULT;
                        r_fault_pc <= r_pc;
                    end else if (w_load) begin
                        r_pc <= r_pc + WORD'(4);
                    end
                end
                default: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_transfer && (r_retired != 32'hFFFF_FFFF)) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    if_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_load  (w_load),
        .i_data  (w_fetch),
        .i_ready (id_ready),
        .o_valid (if_valid),
        .o_data  (w_out)
    );

    assign imem_pc     = r_pc;
    assign if_inst     = w_out.inst;
    assign if_pc       = w_out.pc;
    assign fault       = (r_state == ST_FAULT);
    assign fault_pc    = r_fault_pc;
    assign retired_cnt = r_retired;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: stimulus queues expected (pc, inst) transfers and a
// negedge monitor checks every accepted output; state checks are made directly.
module tb_if_fetch_ctrl;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic        id_ready;
    logic        fault;
    logic [63:0] fault_pc;
    logic [31:0] retired_cnt;

    int   nTests  = 0;
    int   nFailed = 0;
    exp_t sb[$];
    exp_t expEntry;

    always #5 clk = ~clk;

    // Instruction memory model: word k holds the value k.
    assign imem_inst = imem_pc[33:2];

    if_fetch_ctrl #(
        .RESET_PC  (64'h0),
        .MEM_WORDS (1024)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .retired_cnt    (retired_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rv, input logic [63:0] rpc, input logic rdy);
        start          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [63:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        sb.push_back(e);
    endtask

    // Monitor: every accepted, unflushed output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && if_valid && id_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                nTests++;
                nFailed++;
                $display("[TB] FAIL unexpected_transfer: got pc %h, expected no transfer", if_pc);
            end else begin
                expEntry = sb.pop_front();
                checkOutput("xfer_pc", if_pc, expEntry.pc);
                checkOutput("xfer_inst", {32'h0, if_inst}, {32'h0, expEntry.inst});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit faulted;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_imem_pc", imem_pc, 64'h0);
        checkOutput("rst_if_valid", {63'h0, if_valid}, 64'h0);
        checkOutput("rst_if_inst", {32'h0, if_inst}, 64'h0);
        checkOutput("rst_if_pc", if_pc, 64'h0);
        checkOutput("rst_fault", {63'h0, fault}, 64'h0);
        checkOutput("rst_fault_pc", fault_pc, 64'h0);
        checkOutput("rst_retired", {32'h0, retired_cnt}, 64'h0);
        rst_n = 1'b1;
        tick();

        // Start and stream pc 0, 4, then hold pc 8 for three stalled cycles.
        pushExp(64'h0, 32'd0);
        pushExp(64'h4, 32'd1);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("start_pc", imem_pc, 64'h0);
        checkOutput("start_valid", {63'h0, if_valid}, 64'h0);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_valid", {63'h0, if_valid}, 64'h1);
            checkOutput("hold_pc", if_pc, 64'h8);
            checkOutput("hold_inst", {32'h0, if_inst}, 64'h2);
            checkOutput("hold_imem_pc", imem_pc, 64'hC);
            tick();
        end
        checkOutput("hold_retired", {32'h0, retired_cnt}, 64'd2);
        pushExp(64'h8, 32'd2);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        tick();
        checkOutput("release_pc", if_pc, 64'hC);
        checkOutput("release_inst", {32'h0, if_inst}, 64'h3);
        checkOutput("release_retired", {32'h0, retired_cnt}, 64'd3);

        // Redirect to 0x40 while pc 12 is being accepted: pc 12 is flushed, not counted.
        applyStimulus(1'b0, 1'b1, 64'h40, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("redir_valid", {63'h0, if_valid}, 64'h0);
        checkOutput("redir_imem_pc", imem_pc, 64'h40);
        checkOutput("redir_retired", {32'h0, retired_cnt}, 64'd3);
        pushExp(64'h40, 32'd16);
        tick();
        tick();
        checkOutput("redir_next_pc", if_pc, 64'h44);
        checkOutput("redir_next_retired", {32'h0, retired_cnt}, 64'd4);

        // Misaligned redirect target traps on the following fetch attempt.
        applyStimulus(1'b0, 1'b1, 64'h42, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("mis_valid", {63'h0, if_valid}, 64'h0);
        checkOutput("mis_fault_early", {63'h0, fault}, 64'h0);
        checkOutput("mis_imem_pc", imem_pc, 64'h42);
        tick();
        checkOutput("mis_fault", {63'h0, fault}, 64'h1);
        checkOutput("mis_fault_pc", fault_pc, 64'h42);
        checkOutput("mis_valid2", {63'h0, if_valid}, 64'h0);
        applyStimulus(1'b1, 1'b1, 64'h100, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        tick();
        checkOutput("sticky_fault", {63'h0, fault}, 64'h1);
        checkOutput("sticky_imem_pc", imem_pc, 64'h42);
        checkOutput("sticky_valid", {63'h0, if_valid}, 64'h0);
        checkOutput("sticky_retired", {32'h0, retired_cnt}, 64'd4);

        // Asynchronous reset mid-stream with a valid output present.
        rst_n = 1'b0;
        #2;
        checkOutput("arst_fault", {63'h0, fault}, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        pushExp(64'h0, 32'd0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        tick();
        tick();
        checkOutput("pre_arst_valid", {63'h0, if_valid}, 64'h1);
        checkOutput("pre_arst_pc", if_pc, 64'h4);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", {63'h0, if_valid}, 64'h0);
        checkOutput("arst_inst", {32'h0, if_inst}, 64'h0);
        checkOutput("arst_pc", if_pc, 64'h0);
        checkOutput("arst_imem_pc", imem_pc, 64'h0);
        checkOutput("arst_retired", {32'h0, retired_cnt}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("nostart_valid", {63'h0, if_valid}, 64'h0);
        checkOutput("nostart_imem_pc", imem_pc, 64'h0);

        // Full sequential run to the top of memory, then a range fault at 0x1000.
        for (int k = 0; k < 1024; k++) pushExp(64'(k * 4), 32'(k));
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        faulted = 1'b0;
        for (int c = 0; c < 1200 && !faulted; c++) begin
            if (fault) faulted = 1'b1;
            else tick();
        end
        checkOutput("range_fault", {63'h0, fault}, 64'h1);
        checkOutput("range_fault_pc", fault_pc, 64'h1000);
        checkOutput("range_retired", {32'h0, retired_cnt}, 64'd1024);
        checkOutput("range_valid", {63'h0, if_valid}, 64'h0);
        tick();
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
        $finish;
    end

endmodule
